// File: rtl/dcache_2way.sv
// dcache_2way: 2-way set-associative, write-back, write-allocate data cache
// between the MEM stage (p1_*) and the line-wide data memory (mem_*).
module dcache_2way #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_data_i,
  input  logic [31:0]       p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned OFF  = $clog2(LINE_W / 8);
  localparam int unsigned TAG  = 32 - IDX - OFF;
  localparam int unsigned WSEL = OFF - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, REFILLDONE} state_t;

  state_t            state_q, state_d;

  logic [TAG-1:0]    tag_mem  [2][SETS];
  logic [LINE_W-1:0] data_mem [2][SETS];
  logic [SETS-1:0]   valid_q  [2];
  logic [SETS-1:0]   dirty_q  [2];
  logic [SETS-1:0]   lru_q;

  logic              victim_q;
  logic [IDX-1:0]    idx_q;
  logic [TAG-1:0]    ptag_q;

  logic [TAG-1:0]    a_tag;
  logic [IDX-1:0]    a_idx;
  logic [WSEL-1:0]   a_word;
  logic              unused_addr_bits;

  logic              req, hit_w0, hit_w1, hit, hit_way, victim_d, in_idle;
  logic [LINE_W-1:0] hit_line;

  assign a_tag            = p1_addr_i[31 -: TAG];
  assign a_idx            = p1_addr_i[OFF +: IDX];
  assign a_word           = p1_addr_i[2 +: WSEL];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign hit_w0   = valid_q[0][a_idx] && (tag_mem[0][a_idx] == a_tag);
  assign hit_w1   = valid_q[1][a_idx] && (tag_mem[1][a_idx] == a_tag);
  assign hit      = hit_w0 | hit_w1;
  assign hit_way  = hit_w1;
  assign hit_line = data_mem[hit_way][a_idx];
  assign in_idle  = (state_q == IDLE);

  assign p1_stall_o = req & ~(in_idle & hit);
  assign p1_data_o  = (in_idle && p1_MemRead_i && hit) ? hit_line[{a_word, 5'd0} +: 32] : '0;

  // Victim: first invalid way, otherwise the least recently used one.
  always_comb begin
    if (!valid_q[0][a_idx])      victim_d = 1'b0;
    else if (!valid_q[1][a_idx]) victim_d = 1'b1;
    else                         victim_d = lru_q[a_idx];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !hit)
          state_d = (valid_q[victim_d][a_idx] && dirty_q[victim_d][a_idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK:  if (mem_ack_i) state_d = REFILL;
      REFILL:     if (mem_ack_i) state_d = REFILLDONE;
      REFILLDONE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Moore memory-side outputs; the refill address uses the tag latched at the
  // miss, which equals the held p1 tag.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_mem[victim_q][idx_q], idx_q, {OFF{1'b0}}};
        mem_data_o   = data_mem[victim_q][idx_q];
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {ptag_q, idx_q, {OFF{1'b0}}};
      end
      default: ;
    endcase
  end

  // State, line status bits and miss context.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      valid_q  <= '{default: '0};
      dirty_q  <= '{default: '0};
      lru_q    <= '0;
      victim_q <= 1'b0;
      idx_q    <= '0;
      ptag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_idle && req) begin
        if (hit) begin
          lru_q[a_idx] <= ~hit_way;
          if (p1_MemWrite_i) dirty_q[hit_way][a_idx] <= 1'b1;
        end else begin
          victim_q <= victim_d;
          idx_q    <= a_idx;
          ptag_q   <= a_tag;
        end
      end
      if (state_q == REFILL && mem_ack_i) begin
        valid_q[victim_q][idx_q] <= 1'b1;
        dirty_q[victim_q][idx_q] <= 1'b0;
      end
    end
  end

  // Data and tag arrays: store merge on write hit, line fill on refill ack.
  always_ff @(posedge clk_i) begin
    if (in_idle && p1_MemWrite_i && hit)
      data_mem[hit_way][a_idx][{a_word, 5'd0} +: 32] <= p1_data_i;
    if (state_q == REFILL && mem_ack_i) begin
      data_mem[victim_q][idx_q] <= mem_data_i;
      tag_mem[victim_q][idx_q]  <= ptag_q;
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// tb_dcache_2way: directed scoreboard bench for dcache_2way (SETS=16, LINE_W=256).
module tb_dcache_2way;

  localparam int unsigned LAT = 3;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int unsigned stalls;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] w1;
  } mem_exp_t;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_data_i, p1_addr_i;
  logic         p1_MemRead_i, p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o, mem_write_o;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  int       checks = 0;
  int       errors = 0;
  logic     mem_hold = 1'b0;
  int       inject_req = 0;
  int       inject_seen = 0;

  always #5 clk = ~clk;

  dcache_2way #(.SETS(16), .LINE_W(256)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .p1_data_i    (p1_data_i),
    .p1_addr_i    (p1_addr_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o)
  );

  // Memory contents: word i of the line at a = (a/0x200 + 1) * 0x11111111 + i.
  function automatic logic [255:0] line_for(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = ((a >> 9) + 32'd1) * 32'h11111111 + 32'(i);
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] w1);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.w1 = w1;
    mem_q.push_back(m);
  endtask

  // Called at posedge+1; issues one access and holds it until the stall drops.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int unsigned exp_stalls);
    cpu_exp_t e;
    bit done;
    done = 1'b0;
    e.is_read = !we; e.data = exp_data; e.stalls = exp_stalls;
    cpu_q.push_back(e);
    p1_addr_i = addr; p1_data_i = wdata;
    p1_MemWrite_i = we; p1_MemRead_i = !we;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!p1_stall_o) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout: addr %0h still stalled after 64 cycles, required completion", addr);
    end
    @(posedge clk); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  // Memory responder: ack LAT cycles into each transaction, or on injection.
  initial begin : mem_resp
    int unsigned cnt;
    cnt = 0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (inject_req != inject_seen) begin
        mem_ack_i   = 1'b1;
        mem_data_i  = line_for(32'h400);
        inject_seen = inject_req;
      end else if (mem_enable_o && !mem_hold) begin
        cnt++;
        if (cnt == LAT) begin
          mem_ack_i = 1'b1;
          cnt = 0;
          if (!mem_write_o) mem_data_i = line_for(mem_addr_o);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // CPU-side monitor: on each completed access, pop and compare.
  initial begin : cpu_mon
    int unsigned stall_cnt;
    cpu_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_i || !(p1_MemRead_i || p1_MemWrite_i)) begin
        stall_cnt = 0;
      end else if (p1_stall_o) begin
        stall_cnt++;
      end else begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected: completion at addr %0h, required none pending", p1_addr_i);
        end else begin
          e = cpu_q.pop_front();
          check("stall_cycles", 256'(stall_cnt), 256'(e.stalls));
          if (e.is_read) check("load_data", 256'(p1_data_o), 256'(e.data));
        end
        stall_cnt = 0;
      end
    end
  end

  // Memory-side monitor: on each new transaction, pop and compare.
  initial begin : mem_mon
    logic prev_en, prev_we;
    mem_exp_t m;
    prev_en = 1'b0; prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_enable_o && (!prev_en || prev_we != mem_write_o)) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: transaction we=%0b addr %0h, required none", mem_write_o, mem_addr_o);
        end else begin
          m = mem_q.pop_front();
          check("mem_write", 256'(mem_write_o), 256'(m.we));
          check("mem_addr", 256'(mem_addr_o), 256'(m.addr));
          if (m.we) check("wb_word1", 256'(mem_data_o[63:32]), 256'(m.w1));
          else      check("refill_mem_data_o", mem_data_o, '0);
        end
      end
      prev_en = mem_enable_o; prev_we = mem_write_o;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin : stim
    rst_i = 1'b1;
    p1_data_i = '0; p1_addr_i = '0;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    repeat (2) @(posedge clk); #1;

    check("rst_mem_enable", 256'(mem_enable_o), '0);
    check("rst_mem_write", 256'(mem_write_o), '0);
    check("rst_mem_addr", 256'(mem_addr_o), '0);
    check("rst_mem_data", mem_data_o, '0);
    check("rst_p1_data", 256'(p1_data_o), '0);
    check("rst_stall_noreq", 256'(p1_stall_o), '0);
    p1_MemRead_i = 1'b1; #1;
    check("rst_stall_req", 256'(p1_stall_o), 256'(1));
    p1_MemRead_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1;

    push_mem(1'b0, 32'h000, '0);
    access(1'b0, 32'h000, '0, 32'h11111111, 5);
    access(1'b1, 32'h004, 32'hDEADBEEF, '0, 0);
    access(1'b0, 32'h004, '0, 32'hDEADBEEF, 0);
    push_mem(1'b0, 32'h200, '0);
    access(1'b0, 32'h200, '0, 32'h22222222, 5);
    access(1'b0, 32'h000, '0, 32'h11111111, 0);
    access(1'b0, 32'h208, '0, 32'h22222224, 0);
    access(1'b0, 32'h004, '0, 32'hDEADBEEF, 0);
    push_mem(1'b0, 32'h400, '0);
    access(1'b0, 32'h400, '0, 32'h33333333, 5);
    push_mem(1'b1, 32'h000, 32'hDEADBEEF);
    push_mem(1'b0, 32'h200, '0);
    access(1'b0, 32'h200, '0, 32'h22222222, 8);
    access(1'b0, 32'h40C, '0, 32'h33333336, 0);

    // Reset in the middle of a refill; the held-back ack arrives afterwards.
    push_mem(1'b0, 32'h000, '0);
    mem_hold = 1'b1;
    p1_addr_i = 32'h000; p1_MemRead_i = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("refill_pending", 256'(mem_enable_o), 256'(1));
    rst_i = 1'b1; p1_MemRead_i = 1'b0;
    #1;
    check("midrst_mem_enable", 256'(mem_enable_o), '0);
    check("midrst_mem_write", 256'(mem_write_o), '0);
    check("midrst_mem_addr", 256'(mem_addr_o), '0);
    check("midrst_stall_noreq", 256'(p1_stall_o), '0);
    p1_MemRead_i = 1'b1; #1;
    check("midrst_stall_req", 256'(p1_stall_o), 256'(1));
    check("midrst_p1_data", 256'(p1_data_o), '0);
    p1_MemRead_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0; mem_hold = 1'b0;
    inject_req++;
    @(posedge clk); #1;
    check("late_ack_ignored", 256'(mem_enable_o), '0);
    @(posedge clk); #1;
    check("late_ack_still_idle", 256'(mem_enable_o), '0);

    push_mem(1'b0, 32'h000, '0);
    access(1'b0, 32'h000, '0, 32'h11111111, 5);

    repeat (4) @(posedge clk);
    check("cpu_queue_drained", 256'(cpu_q.size()), '0);
    check("mem_queue_drained", 256'(mem_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
